// File: rtl/rotate_arbiter.sv
// Two-requester round-robin front end sharing one 16-bit rotate-right unit.
// Latency: 1 cycle from accept to rsp_valid. Throughput is one result per cycle.
// Backpressure: both readys drop while the result register is full and rsp_ready is low.
module rotate_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id
);

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } rsp_t;

    rsp_t        rsp_q;
    logic        rsp_vld_q;
    logic        last_grant;
    logic        slot_free;
    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic [15:0] sel_data;
    logic [3:0]  sel_amt;
    logic [31:0] rot_wide;

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        slot_free = !rsp_vld_q || rsp_ready;
        grant0    = req0_valid && (!req1_valid || last_grant);
        grant1    = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0 && slot_free && !rst;
    assign req1_ready = grant1 && slot_free && !rst;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    // Only one grant can be live, so a single rotator serves both requesters.
    always_comb begin
        sel_data = grant1 ? req1_data : req0_data;
        sel_amt  = grant1 ? req1_amt  : req0_amt;
        rot_wide = {sel_data, sel_data} >> sel_amt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_q      <= '0;
            last_grant <= 1'b1;
        end else if (accept0 || accept1) begin
            rsp_vld_q  <= 1'b1;
            rsp_q.id   <= accept1;
            rsp_q.data <= rot_wide[15:0];
            last_grant <= accept1;
        end else if (rsp_ready) begin
            rsp_vld_q  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_id    = rsp_q.id;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter: expected values are hand-computed rotations.
module tb_rotate_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_data;
    logic [3:0]  req0_amt;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_data;
    logic [3:0]  req1_amt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;

    int total = 0;
    int bad   = 0;

    rotate_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [15:0] d, input logic id);
        check({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
        check({tag, "_data"},  {16'd0, rsp_data},  {16'd0, d});
        check({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, r0});
        check({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    logic [15:0] sweep_in  [4];
    logic [3:0]  sweep_amt [4];
    logic [15:0] sweep_exp [4];

    initial begin
        sweep_in[0] = 16'h1234; sweep_amt[0] = 4'd4;  sweep_exp[0] = 16'h4123;
        sweep_in[1] = 16'hABCD; sweep_amt[1] = 4'd8;  sweep_exp[1] = 16'hCDAB;
        sweep_in[2] = 16'h0001; sweep_amt[2] = 4'd15; sweep_exp[2] = 16'h0002;
        sweep_in[3] = 16'h5A5A; sweep_amt[3] = 4'd0;  sweep_exp[3] = 16'h5A5A;

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 16'h0; req0_amt = 4'd0;
        req1_valid = 1'b0; req1_data = 16'h0; req1_amt = 4'd0;
        rsp_ready = 1'b0;

        // Reset state, readys held low even with requests and a free consumer
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        check_rsp("reset", 1'b0, 16'h0000, 1'b0);
        check_rdy("reset", 1'b0, 1'b0);
        req1_valid = 1'b0;
        tick();
        #3 rst = 1'b0;

        // Single op on requester 0, accepted on the first edge after release
        req0_data = 16'h8001; req0_amt = 4'd1;
        #1;
        check_rdy("single", 1'b1, 1'b0);
        tick();
        check_rsp("single", 1'b1, 16'hC000, 1'b0);
        req0_valid = 1'b0;

        // Amount sweep on requester 1, back to back
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req1_data = sweep_in[i]; req1_amt = sweep_amt[i];
            #1;
            check_rdy("sweep", 1'b0, 1'b1);
            tick();
            check_rsp("sweep", 1'b1, sweep_exp[i], 1'b1);
        end
        req1_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Contention from reset: strict alternation starting with requester 0
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h00A0; req0_amt = 4'd0;
        req1_valid = 1'b1; req1_data = 16'h00B1; req1_amt = 4'd0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_rdy("contend", (i % 2) == 0, (i % 2) == 1);
            tick();
            check_rsp("contend", 1'b1, (i % 2) ? 16'h00B1 : 16'h00A0, (i % 2) == 1);
        end

        // Backpressure: held result, both readys low, operand changes ignored
        rsp_ready = 1'b0;
        req0_data = 16'h1111; req0_amt = 4'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rdy("hold", 1'b0, 1'b0);
            tick();
            check_rsp("hold", 1'b1, 16'h00B1, 1'b1);
            if (i == 1) begin
                req0_data = 16'h00F0; req0_amt = 4'd4;
            end
        end
        rsp_ready = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        tick();
        check_rsp("release", 1'b1, 16'h000F, 1'b0);

        // Withdrawal: requester 1 blocked, then drops before the slot frees
        rsp_ready = 1'b0; req0_valid = 1'b0;
        #1;
        check_rdy("blocked", 1'b0, 1'b0);
        tick();
        check_rsp("blocked", 1'b1, 16'h000F, 1'b0);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h0003; req0_amt = 4'd1;
        rsp_ready = 1'b1;
        #1;
        check_rdy("withdraw", 1'b1, 1'b0);
        tick();
        check_rsp("withdraw", 1'b1, 16'h8001, 1'b0);
        // last_grant is now 0, so contention must favour requester 1
        req1_valid = 1'b1;
        #1;
        check_rdy("lastgrant0", 1'b0, 1'b1);

        // Reset mid-flight discards the held result and restores priority to 0
        #1 rst = 1'b1;
        #1;
        check_rsp("midreset", 1'b0, 16'h0000, 1'b0);
        check_rdy("midreset", 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        req0_data = 16'hF000; req0_amt = 4'd12;
        #1;
        check_rdy("postreset", 1'b1, 1'b0);
        tick();
        check_rsp("postreset", 1'b1, 16'h000F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
